mixrad_add_stage: RTL
=====================

# mixrad_add_stage

Clocked, parametrised mixed-radix digit adder stage with a NULL/DATA wavefront handshake. Each of `LANES` lanes adds one one-hot radix-`RA` digit to one one-hot radix-`RB` digit and produces a one-hot radix-(`RA`+`RB`-1) sum. The generic RA/RB form covers the 2+3→4 case and any other radix pair. The stage sits between a wavefront producer and consumer in the NCL sandbox interaction designs. It emulates synchronously the enable/completion link behaviour of the clockless NCL stages, and adds multi-lane completion, a wavefront counter and optional code checking.

## Interface
- `RA`, default 2: radix of operand A; one-hot width RA, RA ≥ 2.
- `RB`, default 3: radix of operand B; one-hot width RB, RB ≥ 2.
- `LANES`, default 1: number of independent digit lanes.
- `CNT_W`, default 8: width of the wavefront counter.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `init_n` input, 1 bit: reset, synchronous, active-low.
- `in_a` input, LANES*RA bits: operand A digits; lane k occupies [k*RA +: RA]. All-zero is NULL.
- `in_b` input, LANES*RB bits: operand B digits, packed the same way.
- `in_ack` output, 1 bit: completion back to the producer. 1 while the output holds DATA, 0 while it holds NULL.
- `out_sum` output, LANES*RS bits: sum digits, where RS = RA+RB-1.
- `out_ack` input, 1 bit: consumer completion. Stage enable = ~`out_ack`.
- `wave_cnt` output, CNT_W bits: number of accepted DATA wavefronts, modulo 2^CNT_W.
- `err` output, 1 bit: sticky illegal-code flag. Tied to 0 unless `MIXRAD_ERR_EN` is defined.

## Operation
- Lane sum: if `in_a` lane k has rail i high and `in_b` lane k has rail j high, then `out_sum` lane k gets rail i+j high and every other rail low.
- Lane DATA-complete: both lane digits are complete. See Configuration for what "complete" means.
- Lane NULL: both lane digits are all-zero.
- FSM, two states:
  - EXPECT_DATA (reset state): when `out_ack`=0 and every lane is DATA-complete, register all lane sums, increment `wave_cnt`, and go to EXPECT_NULL. Otherwise hold.
  - EXPECT_NULL: when `out_ack`=1 and every lane is NULL, clear `out_sum` to all-zero and go to EXPECT_DATA. Otherwise hold.
- `in_ack` is a registered output and equals (state == EXPECT_NULL).
- Partial wavefronts (some lanes complete, some not) never advance the FSM. `out_sum` does not change while the FSM holds.
- Inputs are sampled only at the accepting edge. Input changes while the FSM waits on `out_ack` have no effect.
- `wave_cnt` wraps from 2^CNT_W-1 to 0 without a flag.

## Timing
- Reset (`init_n`=0 at an edge): `out_sum`=0, `in_ack`=0, `wave_cnt`=0, `err`=0, state EXPECT_DATA. Reset wins over any simultaneous transition.
- Reset mid-wavefront: output goes to NULL at the reset edge. The first accept after release requires a fresh DATA wavefront.
- Latency: `out_sum` and `in_ack` update at the first edge where the acceptance condition holds. That is 1 cycle from the condition becoming true.
- Throughput: at most one DATA and one NULL per two cycles, with an ideal consumer.
- Simultaneous events: complete DATA arriving with `out_ack`=1 waits. NULL arriving with `out_ack`=0 waits.

## Configuration
- `MIXRAD_ERR_EN` not defined: a digit is complete when any rail is high (OR-reduce, NCL threshold style). Multi-hot inputs are not checked, and the lane result is the OR of all i+j rails. `err`=0.
- `MIXRAD_ERR_EN` defined: a digit is complete only when exactly one rail is high.
  - In EXPECT_DATA, any digit with 2 or more rails high sets `err`=1 at that edge. That lane is not complete, so the FSM does not accept.
  - `err` clears only on reset.

## Structure
- Package `mixrad_pkg` holds:
  - the function computing RS from RA and RB;
  - the state typedef (EXPECT_DATA, EXPECT_NULL);
  - the one-hot helper functions is_null, is_any and is_onehot.
- Sub-module `mixrad_lane`: combinational one-hot adder for a single lane, plus the lane complete/null/illegal flags. Instantiated LANES times in a generate loop.
- The top level holds the FSM, the output register, `wave_cnt` and `err`.

## Test plan
- RA=2, RB=3, LANES=1: a=01, b=100, out_ack=0 → next edge `out_sum`=0100, `in_ack`=1, `wave_cnt`=1. Then out_ack=1 with inputs NULL → `out_sum`=0, `in_ack`=0.
- All 6 input pairs for 2+3: each sum has exactly one rail high at index i+j (0..3). `wave_cnt`=6 after six DATA/NULL cycles.
- LANES=2: lane0 DATA, lane1 NULL for 5 cycles → no change. Lane1 goes DATA → accepted one edge later.
- DATA held with out_ack=1 for 4 cycles → `out_sum` stays 0. out_ack falls → accept next edge. NULL input with out_ack=0 → no clear.
- CNT_W=2: 5 wavefronts → `wave_cnt` reads 1,2,3,0,1.
- `MIXRAD_ERR_EN`: a=11, b=001 → `err`=1, no accept. Then a=10 → accept, `err` stays 1. `init_n`=0 while holding DATA → all outputs 0 at that edge.

Source files
------------

// File: rtl/mixrad_pkg.sv
// Shared types and one-hot helpers for the mixed-radix adder stage.
package mixrad_pkg;

    // Widest digit the helper functions accept; narrower digits are zero-extended.
    localparam int unsigned MAX_RAILS = 32;

    typedef enum logic [0:0] {
        EXPECT_DATA,
        EXPECT_NULL
    } state_e;

    // Sum radix: digits 0..RA-1 plus 0..RB-1 span 0..RA+RB-2.
    function automatic int unsigned rs_width(input int unsigned ra, input int unsigned rb);
        return ra + rb - 1;
    endfunction

    function automatic logic is_null(input logic [MAX_RAILS-1:0] v);
        return (v == '0);
    endfunction

    function automatic logic is_any(input logic [MAX_RAILS-1:0] v);
        return |v;
    endfunction

    function automatic logic is_onehot(input logic [MAX_RAILS-1:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/mixrad_lane.sv
// Combinational one-hot adder for one digit lane, with complete/null/illegal flags.
// Completion rule depends on MIXRAD_ERR_EN (exactly-one-hot) vs default (any rail).
module mixrad_lane
    import mixrad_pkg::*;
#(
    parameter int unsigned RA = 2,
    parameter int unsigned RB = 3
) (
    input  logic [RA-1:0]                 a,
    input  logic [RB-1:0]                 b,
    output logic [rs_width(RA, RB)-1:0]   sum,
    output logic                          complete,
    output logic                          null_lane,
    output logic                          illegal
);

    logic [MAX_RAILS-1:0] a_ext;
    logic [MAX_RAILS-1:0] b_ext;

    assign a_ext = MAX_RAILS'(a);
    assign b_ext = MAX_RAILS'(b);

    // Rail i of a and rail j of b drive rail i+j; multi-hot inputs OR together.
    always_comb begin
        sum = '0;
        for (int i = 0; i < RA; i++) begin
            for (int j = 0; j < RB; j++) begin
                if (a[i] && b[j]) begin
                    sum[i+j] = 1'b1;
                end
            end
        end
    end

    // Lane status flags.
    always_comb begin
`ifdef MIXRAD_ERR_EN
        complete  = is_onehot(a_ext) && is_onehot(b_ext);
`else
        complete  = is_any(a_ext) && is_any(b_ext);
`endif
        null_lane = is_null(a_ext) && is_null(b_ext);
        illegal   = (is_any(a_ext) && !is_onehot(a_ext)) ||
                    (is_any(b_ext) && !is_onehot(b_ext));
    end

endmodule

// File: rtl/mixrad_add_stage.sv
// Mixed-radix digit adder stage with NULL/DATA wavefront handshake.
// Optional sticky illegal-code flag enabled by defining MIXRAD_ERR_EN.
module mixrad_add_stage
    import mixrad_pkg::*;
#(
    parameter int unsigned RA    = 2,
    parameter int unsigned RB    = 3,
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic                                clk,
    input  logic                                init_n,
    input  logic [LANES*RA-1:0]                 in_a,
    input  logic [LANES*RB-1:0]                 in_b,
    output logic                                in_ack,
    output logic [LANES*rs_width(RA, RB)-1:0]   out_sum,
    input  logic                                out_ack,
    output logic [CNT_W-1:0]                    wave_cnt,
    output logic                                err
);

    localparam int unsigned RS = rs_width(RA, RB);

    logic [LANES*RS-1:0] lane_sum;
    logic [LANES-1:0]    lane_complete;
    logic [LANES-1:0]    lane_null;
    logic [LANES-1:0]    lane_illegal;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mixrad_lane #(
            .RA (RA),
            .RB (RB)
        ) u_lane (
            .a         (in_a[k*RA +: RA]),
            .b         (in_b[k*RB +: RB]),
            .sum       (lane_sum[k*RS +: RS]),
            .complete  (lane_complete[k]),
            .null_lane (lane_null[k]),
            .illegal   (lane_illegal[k])
        );
    end

    logic all_data;
    logic all_null;

    assign all_data = &lane_complete;
    assign all_null = &lane_null;

    state_e              state_q, state_d;
    logic [LANES*RS-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Next-state: accept full DATA when consumer ready, accept full NULL once consumer acked.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EXPECT_DATA: begin
                if (!out_ack && all_data) begin
                    sum_d   = lane_sum;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = EXPECT_NULL;
                end
            end
            EXPECT_NULL: begin
                if (out_ack && all_null) begin
                    sum_d   = '0;
                    state_d = EXPECT_DATA;
                end
            end
            default: state_d = EXPECT_DATA;
        endcase
    end

    // State, output register and wavefront counter.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q <= EXPECT_DATA;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ack   = (state_q == EXPECT_NULL);
    assign out_sum  = sum_q;
    assign wave_cnt = cnt_q;

`ifdef MIXRAD_ERR_EN
    logic err_q, err_d;

    // Multi-hot digits seen while waiting for DATA latch the error until reset.
    always_comb begin
        err_d = err_q;
        if ((state_q == EXPECT_DATA) && (|lane_illegal)) begin
            err_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_illegal;
    assign unused_illegal = ^lane_illegal;
    assign err            = 1'b0;
`endif

endmodule
